parking_lot: RTL and testbench

PARKING_LOT -- requirements
Module: parking_lot

---
 rtl/parking_lot.sv | 93 +++++++++
 tb/tb_parking_lot.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/parking_lot.sv
// parking_lot: entry and exit lane controllers, two concurrent Moore FSMs sharing one RFID reader
module parking_lot (
    input  logic clk,
    input  logic resetn,
    input  logic CarDetectEntry,
    input  logic CarDetectExit,
    input  logic ValidTag1,
    input  logic ValidationFail1,
    input  logic ValidTag2,
    input  logic ValidationFail2,
    input  logic PaymentDone,
    input  logic Timeout1,
    input  logic Timeout2,
    output logic ActivateRFID,
    output logic IssueTicket,
    output logic OpenEntryGate,
    output logic OpenExitGate,
    output logic startTimer1,
    output logic startTimer2,
    output logic InitPayment,
    output logic AssertError
);
    typedef enum logic [1:0] {E_IDLE, E_RFID, E_TICKET, E_OPEN} entryState_t;
    typedef enum logic [2:0] {X_IDLE, X_RFID, X_PAY, X_OPEN, X_ERROR} exitState_t;

    entryState_t entryState, entryNext;
    exitState_t  exitState, exitNext;
    logic        rfidEntry, rfidExit;

    // Entry lane next state; car detect only matters in idle
    always_comb begin
        entryNext = entryState;
        case (entryState)
            E_IDLE:   entryNext = CarDetectEntry ? E_RFID : E_IDLE;
            E_RFID:   entryNext = ValidTag1 ? E_OPEN : (ValidationFail1 ? E_TICKET : E_RFID);
            E_TICKET: entryNext = E_OPEN;
            E_OPEN:   entryNext = Timeout1 ? E_IDLE : E_OPEN;
            default:  entryNext = E_IDLE;
        endcase
    end

    // Entry lane state and registered outputs, decoded from the state being entered
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            entryState    <= E_IDLE;
            rfidEntry     <= 1'b0;
            IssueTicket   <= 1'b0;
            OpenEntryGate <= 1'b0;
            startTimer1   <= 1'b0;
        end else begin
            entryState    <= entryNext;
            rfidEntry     <= entryNext == E_RFID;
            IssueTicket   <= entryNext == E_TICKET;
            OpenEntryGate <= entryNext == E_OPEN;
            startTimer1   <= entryNext == E_OPEN && entryState != E_OPEN;
        end
    end

    // Exit lane next state; the error state always falls back to idle after one cycle
    always_comb begin
        exitNext = exitState;
        case (exitState)
            X_IDLE:  exitNext = CarDetectExit ? X_RFID : X_IDLE;
            X_RFID:  exitNext = ValidTag2 ? X_PAY : (ValidationFail2 ? X_ERROR : X_RFID);
            X_PAY:   exitNext = PaymentDone ? X_OPEN : X_PAY;
            X_OPEN:  exitNext = Timeout2 ? X_IDLE : X_OPEN;
            X_ERROR: exitNext = X_IDLE;
            default: exitNext = X_IDLE;
        endcase
    end

    // Exit lane state and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exitState    <= X_IDLE;
            rfidExit     <= 1'b0;
            InitPayment  <= 1'b0;
            OpenExitGate <= 1'b0;
            startTimer2  <= 1'b0;
            AssertError  <= 1'b0;
        end else begin
            exitState    <= exitNext;
            rfidExit     <= exitNext == X_RFID;
            InitPayment  <= exitNext == X_PAY;
            OpenExitGate <= exitNext == X_OPEN;
            startTimer2  <= exitNext == X_OPEN && exitState != X_OPEN;
            AssertError  <= exitNext == X_ERROR;
        end
    end

    // The reader is shared, so it is enabled while either lane is reading a tag
    assign ActivateRFID = rfidEntry | rfidExit;
endmodule

// File: tb/tb_parking_lot.sv
// tb_parking_lot: randomized scoreboard bench for parking_lot against a lane-phase reference model
module tb_parking_lot;
    logic clk = 1'b0;
    logic resetn;
    logic CarDetectEntry, CarDetectExit, ValidTag1, ValidationFail1, ValidTag2, ValidationFail2;
    logic PaymentDone, Timeout1, Timeout2;
    logic ActivateRFID, IssueTicket, OpenEntryGate, OpenExitGate;
    logic startTimer1, startTimer2, InitPayment, AssertError;

    parking_lot dut (
        .clk(clk), .resetn(resetn),
        .CarDetectEntry(CarDetectEntry), .CarDetectExit(CarDetectExit),
        .ValidTag1(ValidTag1), .ValidationFail1(ValidationFail1),
        .ValidTag2(ValidTag2), .ValidationFail2(ValidationFail2),
        .PaymentDone(PaymentDone), .Timeout1(Timeout1), .Timeout2(Timeout2),
        .ActivateRFID(ActivateRFID), .IssueTicket(IssueTicket),
        .OpenEntryGate(OpenEntryGate), .OpenExitGate(OpenExitGate),
        .startTimer1(startTimer1), .startTimer2(startTimer2),
        .InitPayment(InitPayment), .AssertError(AssertError)
    );

    always #5 clk = ~clk;

    // {ActivateRFID, IssueTicket, OpenEntryGate, OpenExitGate, startTimer1, startTimer2, InitPayment, AssertError}
    wire [7:0] got = {ActivateRFID, IssueTicket, OpenEntryGate, OpenExitGate,
                      startTimer1, startTimer2, InitPayment, AssertError};

    logic [7:0] expQ[$];
    int tests = 0;
    int failed = 0;
    int cycle = 0;

    // Reference model: what each lane is doing, and how long its gate has been open
    typedef enum {WAIT_CAR, READ_TAG, PRINT_TICKET, PAYING, GATE_OPEN, TAG_ERROR} lane_t;
    lane_t entryLane, exitLane;
    int entryOpenAge, exitOpenAge;

    function automatic lane_t advance(input lane_t cur, input bit isEntry, input bit car,
                                      input bit tagOk, input bit tagBad, input bit paid, input bit tmo);
        if (cur == WAIT_CAR) return car ? READ_TAG : WAIT_CAR;
        if (cur == READ_TAG) begin
            if (tagOk) return isEntry ? GATE_OPEN : PAYING;
            if (tagBad) return isEntry ? PRINT_TICKET : TAG_ERROR;
            return READ_TAG;
        end
        if (cur == PRINT_TICKET) return GATE_OPEN;
        if (cur == PAYING) return paid ? GATE_OPEN : PAYING;
        if (cur == GATE_OPEN) return tmo ? WAIT_CAR : GATE_OPEN;
        return WAIT_CAR;
    endfunction

    task automatic modelStep(output logic [7:0] e);
        lane_t ne, nx;
        ne = advance(entryLane, 1'b1, CarDetectEntry, ValidTag1, ValidationFail1, 1'b0, Timeout1);
        nx = advance(exitLane, 1'b0, CarDetectExit, ValidTag2, ValidationFail2, PaymentDone, Timeout2);
        entryOpenAge = (ne == GATE_OPEN && entryLane == GATE_OPEN) ? entryOpenAge + 1 : 0;
        exitOpenAge  = (nx == GATE_OPEN && exitLane == GATE_OPEN) ? exitOpenAge + 1 : 0;
        entryLane = ne;
        exitLane = nx;
        e = {entryLane == READ_TAG || exitLane == READ_TAG,
             entryLane == PRINT_TICKET,
             entryLane == GATE_OPEN,
             exitLane == GATE_OPEN,
             entryLane == GATE_OPEN && entryOpenAge == 0,
             exitLane == GATE_OPEN && exitOpenAge == 0,
             exitLane == PAYING,
             exitLane == TAG_ERROR};
    endtask

    // Monitor: compare the DUT against the oldest expectation shortly after each edge
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                tests++;
                if (got !== e) begin
                    failed++;
                    $display("FAIL outputs cycle %0d: got %b want %b", cycle, got, e);
                end
            end
        end
    end

    // Stimulus: randomized lane activity with occasional mid-cycle resets
    initial begin
        logic [7:0] e;
        int rstLeft;
        resetn = 1'b0;
        {CarDetectEntry, CarDetectExit, ValidTag1, ValidationFail1, ValidTag2,
         ValidationFail2, PaymentDone, Timeout1, Timeout2} = '0;
        entryLane = WAIT_CAR;
        exitLane = WAIT_CAR;
        entryOpenAge = 0;
        exitOpenAge = 0;
        rstLeft = 2;
        repeat (2) @(negedge clk);
        tests++;
        if (got !== 8'h00) begin
            failed++;
            $display("FAIL power-on reset outputs: got %b want 00000000", got);
        end
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!resetn && rstLeft == 0) resetn = 1'b1;
            else if (resetn && $urandom_range(0, 149) == 0) begin
                resetn = 1'b0;
                rstLeft = $urandom_range(1, 3);
                entryLane = WAIT_CAR;
                exitLane = WAIT_CAR;
                #1;
                tests++;
                if (got !== 8'h00) begin
                    failed++;
                    $display("FAIL async reset outputs: got %b want 00000000", got);
                end
            end
            CarDetectEntry  = $urandom_range(0, 3) == 0;
            CarDetectExit   = $urandom_range(0, 3) == 0;
            ValidTag1       = $urandom_range(0, 3) == 0;
            ValidationFail1 = $urandom_range(0, 3) == 0;
            ValidTag2       = $urandom_range(0, 3) == 0;
            ValidationFail2 = $urandom_range(0, 3) == 0;
            PaymentDone     = $urandom_range(0, 2) == 0;
            Timeout1        = $urandom_range(0, 2) == 0;
            Timeout2        = $urandom_range(0, 2) == 0;
            if (!resetn) begin
                rstLeft--;
                expQ.push_back(8'h00);
            end else begin
                modelStep(e);
                expQ.push_back(e);
            end
        end
        repeat (3) @(negedge clk);
        tests++;
        if (expQ.size() != 0) begin
            failed++;
            $display("FAIL scoreboard drain: got %0d pending want 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
